// File: rtl/cosim_trace_queue_if.sv
// Trace-port bundle between a retiring core (master side), the co-simulation
// checker, and the trace queue (slave side).
interface cosim_trace_queue_if #(
  parameter int NLANES = 2,
  parameter int DEPTH  = 8,
  parameter int XLEN   = 64,
  parameter int VWORDS = 8
);
  logic [63:0]                 cycle;
  logic [NLANES-1:0]           in_valid;
  logic [NLANES-1:0]           in_exception;
  logic [NLANES-1:0]           in_interrupt;
  logic [NLANES*XLEN-1:0]      in_iaddr;
  logic [NLANES*32-1:0]        in_insn;
  logic [NLANES*XLEN-1:0]      in_cause;
  logic [NLANES-1:0]           in_has_wdata;
  logic [NLANES-1:0]           in_has_vwdata;
  logic [NLANES*XLEN-1:0]      in_wdata;
  logic [NLANES*3-1:0]         in_priv;
  logic [NLANES*VWORDS*64-1:0] in_vwdata;

  logic                        out_valid;
  logic                        out_ready;
  logic [63:0]                 out_seq;
  logic [63:0]                 out_cycle;
  logic                        out_valid_insn;
  logic                        out_exception;
  logic                        out_interrupt;
  logic                        out_has_wdata;
  logic                        out_has_vwdata;
  logic [XLEN-1:0]             out_iaddr;
  logic [XLEN-1:0]             out_cause;
  logic [XLEN-1:0]             out_wdata;
  logic [31:0]                 out_insn;
  logic [2:0]                  out_priv;
  logic [VWORDS*64-1:0]        out_vwdata;

  logic                        stall;
  logic [$clog2(DEPTH):0]      count;
  logic                        overflow;
  logic [15:0]                 drop_count;

  modport master (
    output cycle, in_valid, in_exception, in_interrupt, in_iaddr, in_insn, in_cause,
           in_has_wdata, in_has_vwdata, in_wdata, in_priv, in_vwdata, out_ready,
    input  out_valid, out_seq, out_cycle, out_valid_insn, out_exception, out_interrupt,
           out_has_wdata, out_has_vwdata, out_iaddr, out_cause, out_wdata, out_insn,
           out_priv, out_vwdata, stall, count, overflow, drop_count
  );

  modport slave (
    input  cycle, in_valid, in_exception, in_interrupt, in_iaddr, in_insn, in_cause,
           in_has_wdata, in_has_vwdata, in_wdata, in_priv, in_vwdata, out_ready,
    output out_valid, out_seq, out_cycle, out_valid_insn, out_exception, out_interrupt,
           out_has_wdata, out_has_vwdata, out_iaddr, out_cause, out_wdata, out_insn,
           out_priv, out_vwdata, stall, count, overflow, drop_count
  );
endinterface

// File: rtl/cosim_trace_queue.sv
// Retire-trace collector: compacts up to NLANES retired/trapped instructions
// per cycle into a DEPTH-entry FIFO and drains one record per cycle.
module cosim_trace_queue #(
  parameter int NLANES = 2,
  parameter int DEPTH  = 8,
  parameter int XLEN   = 64,
  parameter int VWORDS = 8
) (
  input  logic               clock,
  input  logic               reset,
  cosim_trace_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int VW = VWORDS * 64;

  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    logic [63:0]     seq;
    logic [63:0]     cyc;
    logic            valid_insn;
    logic            exception;
    logic            interrupt;
    logic            has_wdata;
    logic            has_vwdata;
    logic [XLEN-1:0] iaddr;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] wdata;
    logic [31:0]     insn;
    logic [2:0]      priv;
    logic [VW-1:0]   vwdata;
  } rec_t;

  rec_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  cnt_t          r_count;
  logic [63:0]   r_seq;
  logic          r_overflow;
  logic          r_stall;
  logic [15:0]   r_drop;

  rec_t              w_lane_rec [NLANES];
  cnt_t              w_rank     [NLANES];
  logic [NLANES-1:0] w_active;
  logic [NLANES-1:0] w_take;
  cnt_t              w_free;
  cnt_t              w_nact;
  cnt_t              w_nacc;
  cnt_t              w_ndrop;
  cnt_t              w_count_next;
  logic              w_pop;
  logic [16:0]       w_drop_sum;
  rec_t              w_head;

  // Each active lane's rank among active lanes is its compacted slot offset;
  // only ranks below the pre-pop free space are accepted.
  // NOTE: w_nact/w_nacc are running accumulators inside the loop, so they
  // must use blocking assignments here; each iteration sees the prior sum.
  always_comb begin
    w_free = cnt_t'(DEPTH) - r_count;
    w_nact = '0;
    w_nacc = '0;
    for (int i = 0; i < NLANES; i++) begin
      w_active[i] = bus.in_valid[i] | bus.in_exception[i] | bus.in_interrupt[i];
      w_rank[i]   = w_nact;
      w_take[i]   = w_active[i] && (w_nact < w_free);
      if (w_active[i]) w_nact = w_nact + cnt_t'(1);
      if (w_take[i])   w_nacc = w_nacc + cnt_t'(1);

      w_lane_rec[i].seq        = r_seq + 64'(w_rank[i]);
      w_lane_rec[i].cyc        = bus.cycle;
      w_lane_rec[i].valid_insn = bus.in_valid[i];
      w_lane_rec[i].exception  = bus.in_exception[i];
      w_lane_rec[i].interrupt  = bus.in_interrupt[i];
      w_lane_rec[i].has_wdata  = bus.in_has_wdata[i];
      w_lane_rec[i].has_vwdata = bus.in_has_vwdata[i];
      w_lane_rec[i].iaddr      = bus.in_iaddr[i*XLEN +: XLEN];
      w_lane_rec[i].cause      = bus.in_cause[i*XLEN +: XLEN];
      w_lane_rec[i].wdata      = bus.in_wdata[i*XLEN +: XLEN];
      w_lane_rec[i].insn       = bus.in_insn[i*32 +: 32];
      w_lane_rec[i].priv       = bus.in_priv[i*3 +: 3];
      w_lane_rec[i].vwdata     = bus.in_vwdata[i*VW +: VW];
    end
    w_ndrop = w_nact - w_nacc;
  end

  assign w_pop        = (r_count != '0) & bus.out_ready;
  assign w_count_next = r_count + w_nacc - cnt_t'(w_pop);
  assign w_drop_sum   = {1'b0, r_drop} + 17'(w_ndrop);

  // NOTE: the record storage has no reset; occupancy alone says which
  // entries are live, so clearing the array would only cost reset fanout.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NLANES; i++) begin
      if (w_take[i]) r_mem[r_wr_ptr + PW'(w_rank[i])] <= w_lane_rec[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_overflow <= 1'b0;
      r_stall    <= 1'b0;
      r_drop     <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_nacc);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count  <= w_count_next;
      r_seq    <= r_seq + 64'(w_nacc);
      if (w_ndrop != '0) begin
        r_overflow <= 1'b1;
        r_drop     <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
      // Margin of two full retire groups covers a core that reacts a cycle late.
      r_stall <= (cnt_t'(DEPTH) - w_count_next) < cnt_t'(2 * NLANES);
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign bus.out_valid      = (r_count != '0);
  assign bus.out_seq        = w_head.seq;
  assign bus.out_cycle      = w_head.cyc;
  assign bus.out_valid_insn = w_head.valid_insn;
  assign bus.out_exception  = w_head.exception;
  assign bus.out_interrupt  = w_head.interrupt;
  assign bus.out_has_wdata  = w_head.has_wdata;
  assign bus.out_has_vwdata = w_head.has_vwdata;
  assign bus.out_iaddr      = w_head.iaddr;
  assign bus.out_cause      = w_head.cause;
  assign bus.out_wdata      = w_head.wdata;
  assign bus.out_insn       = w_head.insn;
  assign bus.out_priv       = w_head.priv;
  assign bus.out_vwdata     = w_head.vwdata;
  assign bus.stall          = r_stall;
  assign bus.count          = r_count;
  assign bus.overflow       = r_overflow;
  assign bus.drop_count     = r_drop;
endmodule

// File: tb/tb_cosim_trace_queue.sv
// Bench for cosim_trace_queue: queue-based reference model checked every
// falling edge, plus directed vectors with literal expectations.
module tb_cosim_trace_queue;
  localparam int NLANES = 2;
  localparam int DEPTH  = 8;
  localparam int XLEN   = 64;
  localparam int VWORDS = 8;
  localparam int VW     = VWORDS * 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cosim_trace_queue_if #(.NLANES(NLANES), .DEPTH(DEPTH), .XLEN(XLEN), .VWORDS(VWORDS)) bus ();

  cosim_trace_queue #(.NLANES(NLANES), .DEPTH(DEPTH), .XLEN(XLEN), .VWORDS(VWORDS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of records, filled and drained by the rules.
  typedef struct {
    logic [63:0]   seq;
    logic [63:0]   cyc;
    logic          vi, ex, it, hw, hv;
    logic [63:0]   iaddr, cause, wdata;
    logic [31:0]   insn;
    logic [2:0]    priv;
    logic [VW-1:0] vw;
  } rec_t;

  rec_t        m_q[$];
  logic [63:0] m_seq   = '0;
  int          m_drops = 0;
  bit          m_ovf   = 1'b0;
  bit          m_stall = 1'b0;

  initial begin
    rec_t r;
    int   free;
    bit   pop;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_q.delete();
        m_seq   = '0;
        m_drops = 0;
        m_ovf   = 1'b0;
        m_stall = 1'b0;
      end else if (clock) begin
        free = DEPTH - m_q.size();
        pop  = (m_q.size() != 0) && bus.out_ready;
        if (pop) void'(m_q.pop_front());
        for (int i = 0; i < NLANES; i++) begin
          if (bus.in_valid[i] || bus.in_exception[i] || bus.in_interrupt[i]) begin
            if (free > 0) begin
              r.seq   = m_seq;
              r.cyc   = bus.cycle;
              r.vi    = bus.in_valid[i];
              r.ex    = bus.in_exception[i];
              r.it    = bus.in_interrupt[i];
              r.hw    = bus.in_has_wdata[i];
              r.hv    = bus.in_has_vwdata[i];
              r.iaddr = bus.in_iaddr[i*XLEN +: XLEN];
              r.cause = bus.in_cause[i*XLEN +: XLEN];
              r.wdata = bus.in_wdata[i*XLEN +: XLEN];
              r.insn  = bus.in_insn[i*32 +: 32];
              r.priv  = bus.in_priv[i*3 +: 3];
              r.vw    = bus.in_vwdata[i*VW +: VW];
              m_q.push_back(r);
              m_seq++;
              free--;
            end else begin
              m_ovf = 1'b1;
              if (m_drops < 65535) m_drops++;
            end
          end
        end
        m_stall = (DEPTH - m_q.size()) < 2 * NLANES;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      check("out_valid", bus.out_valid, m_q.size() != 0);
      check("count", bus.count, m_q.size());
      check("stall", bus.stall, m_stall);
      check("overflow", bus.overflow, m_ovf);
      check("drop_count", bus.drop_count, m_drops);
      if (m_q.size() != 0) begin
        check("head_seq", bus.out_seq, m_q[0].seq);
        check("head_cycle", bus.out_cycle, m_q[0].cyc);
        check("head_flags",
              {bus.out_valid_insn, bus.out_exception, bus.out_interrupt, bus.out_has_wdata, bus.out_has_vwdata},
              {m_q[0].vi, m_q[0].ex, m_q[0].it, m_q[0].hw, m_q[0].hv});
        check("head_iaddr", bus.out_iaddr, m_q[0].iaddr);
        check("head_cause", bus.out_cause, m_q[0].cause);
        check("head_wdata", bus.out_wdata, m_q[0].wdata);
        check("head_insn", bus.out_insn, m_q[0].insn);
        check("head_priv", bus.out_priv, m_q[0].priv);
        check("head_vwdata", bus.out_vwdata, m_q[0].vw);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic clear_lanes();
    bus.in_valid      = '0;
    bus.in_exception  = '0;
    bus.in_interrupt  = '0;
    bus.in_iaddr      = '0;
    bus.in_insn       = '0;
    bus.in_cause      = '0;
    bus.in_has_wdata  = '0;
    bus.in_has_vwdata = '0;
    bus.in_wdata      = '0;
    bus.in_priv       = '0;
    bus.in_vwdata     = '0;
  endtask

  task automatic set_lane(input int l, input logic v, input logic ex, input logic it,
                          input logic [63:0] pc, input logic [63:0] cause);
    bus.in_valid[l]             = v;
    bus.in_exception[l]         = ex;
    bus.in_interrupt[l]         = it;
    bus.in_iaddr[l*XLEN +: XLEN] = pc;
    bus.in_cause[l*XLEN +: XLEN] = cause;
    bus.in_insn[l*32 +: 32]     = pc[31:0] ^ 32'h0000_0013;
    bus.in_wdata[l*XLEN +: XLEN] = ~pc;
    bus.in_has_wdata[l]         = v;
    bus.in_has_vwdata[l]        = v & (l == 1);
    bus.in_priv[l*3 +: 3]       = 3'(l + 1);
    bus.in_vwdata[l*VW +: VW]   = {VWORDS{pc ^ cause}};
  endtask

  // Advance past one rising edge and land just after the following falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  int exp_count [5] = '{2, 4, 6, 8, 8};
  int exp_stall [5] = '{0, 0, 1, 1, 1};
  int exp_drop  [5] = '{0, 0, 0, 0, 2};

  initial begin
    clear_lanes();
    bus.out_ready = 1'b1;
    bus.cycle     = '0;
    tick();
    tick();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_count", bus.count, 0);
    check("rst_stall", bus.stall, 1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_drop", bus.drop_count, 0);
    reset = 1'b1;

    // Single lane 1 record.
    bus.cycle = 64'd100;
    set_lane(1, 1'b1, 1'b0, 1'b0, 64'h8000_0004, 64'h0);
    tick();
    clear_lanes();
    check("single_valid", bus.out_valid, 1'b1);
    check("single_iaddr", bus.out_iaddr, 64'h8000_0004);
    check("single_seq", bus.out_seq, 0);
    check("single_cycle", bus.out_cycle, 64'd100);
    tick();
    check("single_drained", bus.out_valid, 1'b0);

    // Two lanes in one cycle come out in lane order.
    bus.cycle = 64'd101;
    set_lane(0, 1'b1, 1'b0, 1'b0, 64'h8000_0000, 64'h0);
    set_lane(1, 1'b1, 1'b0, 1'b0, 64'h8000_0004, 64'h0);
    tick();
    clear_lanes();
    check("order_first_iaddr", bus.out_iaddr, 64'h8000_0000);
    check("order_first_seq", bus.out_seq, 1);
    check("order_count", bus.count, 2);
    tick();
    check("order_second_iaddr", bus.out_iaddr, 64'h8000_0004);
    check("order_second_seq", bus.out_seq, 2);
    tick();
    check("order_drained", bus.out_valid, 1'b0);

    // Interrupt-only lane is captured; flagless lane with a cause is not.
    bus.cycle = 64'd102;
    set_lane(0, 1'b0, 1'b0, 1'b1, 64'h8000_0100, 64'h8000_0000_0000_0007);
    set_lane(1, 1'b0, 1'b0, 1'b0, 64'h8000_0008, 64'h2);
    tick();
    clear_lanes();
    check("trap_valid_insn", bus.out_valid_insn, 1'b0);
    check("trap_interrupt", bus.out_interrupt, 1'b1);
    check("trap_cause", bus.out_cause, 64'h8000_0000_0000_0007);
    check("trap_count", bus.count, 1);
    tick();
    check("trap_no_second", bus.out_valid, 1'b0);

    // Backpressure: fill, stall, then overflow.
    bus.out_ready = 1'b0;
    for (int p = 0; p < 5; p++) begin
      bus.cycle = 64'(200 + p);
      set_lane(0, 1'b1, 1'b0, 1'b0, 64'h9000_0000 + 64'(p * 8), 64'h0);
      set_lane(1, 1'b1, 1'b0, 1'b0, 64'h9000_0004 + 64'(p * 8), 64'h0);
      tick();
      check("bp_count", bus.count, exp_count[p]);
      check("bp_stall", bus.stall, exp_stall[p]);
      check("bp_drop", bus.drop_count, exp_drop[p]);
    end
    clear_lanes();
    check("bp_overflow", bus.overflow, 1'b1);
    check("bp_head_seq", bus.out_seq, 4);
    check("bp_head_iaddr", bus.out_iaddr, 64'h9000_0000);

    // Full with a simultaneous pop: the pop does not make room for the push.
    bus.out_ready = 1'b1;
    set_lane(0, 1'b1, 1'b0, 1'b0, 64'hA000_0000, 64'h0);
    tick();
    clear_lanes();
    check("fullpop_count", bus.count, 7);
    check("fullpop_drop", bus.drop_count, 3);
    check("fullpop_head_seq", bus.out_seq, 5);

    // Drain to 5, then reset between edges.
    tick();
    tick();
    bus.out_ready = 1'b0;
    check("pre_reset_count", bus.count, 5);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_valid", bus.out_valid, 1'b0);
    check("async_reset_count", bus.count, 0);
    tick();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    bus.cycle = 64'd300;
    set_lane(0, 1'b1, 1'b0, 1'b0, 64'h8000_1000, 64'h0);
    tick();
    clear_lanes();
    check("post_reset_seq", bus.out_seq, 0);
    check("post_reset_iaddr", bus.out_iaddr, 64'h8000_1000);
    check("post_reset_overflow", bus.overflow, 1'b0);

    // Mixed lane patterns against intermittent ready; the model checks every cycle.
    for (int i = 0; i < 40; i++) begin
      bus.cycle     = 64'(400 + i);
      bus.out_ready = (i % 3) != 0;
      set_lane(0, 1'((i % 4) & 1), 1'(i % 5 == 0), 1'b0, 64'hB000_0000 + 64'(i * 16), 64'(i));
      set_lane(1, 1'(((i % 4) >> 1) & 1), 1'b0, 1'(i % 7 == 3), 64'hB000_0008 + 64'(i * 16), 64'(i + 1));
      tick();
    end
    clear_lanes();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("final_drained", bus.out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
